ro_freq_meter: RTL and testbench
================================

RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the RO edge count result.
REQ-002 Parameter WIN_W, default 16: width of the gate-window length input.
REQ-003 Parameter SETTLE_CYC, default 4: number of clk cycles the oscillator runs before gating.
REQ-004 clk  input  1  system clock; the only clock driving control logic.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  single-cycle measurement request, sampled on clk.
REQ-007 win_cycles  input  WIN_W  gate length in clk cycles, captured when start is accepted.
REQ-008 ro_in  input  1  oscillator output to be counted; asynchronous to clk.
REQ-009 ro_activate  output  1  oscillator enable request to the ring oscillator.
REQ-010 busy  output  1  high while a measurement is in progress.
REQ-011 valid  output  1  high while count holds a completed result.
REQ-012 count  output  CNT_W  number of ro_in rising edges inside the gate window.
REQ-013 overflow  output  1  high when the edge count saturated during the window.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SETTLE, GATE, DRAIN, SAMPLE and DONE.
REQ-015 A start pulse SHALL be accepted only in IDLE or DONE.
- Accepting start: captures win_cycles, clears count, clears valid and clears overflow.
- Transition: next state is SETTLE.
REQ-016 A start pulse in SETTLE, GATE, DRAIN or SAMPLE SHALL be ignored.
REQ-017 SETTLE SHALL last SETTLE_CYC cycles with ro_activate=1 and gate=0.
REQ-018 GATE SHALL last exactly the captured win_cycles clk cycles with gate=1.
REQ-019 A captured win_cycles of 0 SHALL skip GATE, i.e. SETTLE goes directly to DRAIN, giving count=0.
REQ-020 DRAIN SHALL last 4 cycles with gate=0 and ro_activate=1, so the gate-low propagates through the RO-domain synchronizer.
REQ-021 SAMPLE SHALL last 2 cycles, bringing the now-static RO-domain count into clk through a 2-flop stage.
REQ-022 At the end of SAMPLE, the FSM SHALL register count and overflow and then enter DONE.
REQ-023 ro_activate SHALL be 1 in SETTLE, GATE and DRAIN, and 0 in IDLE, SAMPLE and DONE.
REQ-024 busy SHALL be 1 in every state except IDLE and DONE.
REQ-025 valid SHALL be 1 only in DONE; count and overflow SHALL hold stable in DONE until the next accepted start.
REQ-026 Latency: valid SHALL rise win_cycles+SETTLE_CYC+7 clk cycles after the edge that accepts start.
- With the default SETTLE_CYC this is win_cycles+11 cycles.
REQ-027 The RO-domain counter SHALL increment on each ro_in rising edge while its synchronized gate is 1.
REQ-028 The RO-domain counter SHALL saturate at 2^CNT_W-1 and set a sticky overflow bit; it SHALL never wrap.
REQ-029 The RO-domain counter and overflow bit SHALL be asynchronously cleared by rst or by a clk-domain clear register, which is asserted in IDLE and on start acceptance and deasserted in SETTLE.
REQ-030 The gate SHALL enter the RO domain through a 2-flop synchronizer clocked by ro_in; count accuracy SHALL be within ±2 edges of ideal.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE with ro_activate=0, busy=0, valid=0, count=0, overflow=0, gate=0 and the clear register asserted.
REQ-032 rst asserted mid-measurement SHALL abort immediately, with no result retained and ro_activate dropping asynchronously.
REQ-033 After rst release, the block SHALL accept start on the first clk edge.

Structure
REQ-034 The state encoding, the DRAIN and SAMPLE lengths (4 and 2), and the default widths SHALL live in the shared package ro_meter_pkg.
REQ-035 The RO-clocked logic SHALL be the sub-module ro_edge_counter, containing:
- gate synchronizer;
- saturating counter;
- sticky overflow bit;
- asynchronous clear input.
REQ-036 The top-level ro_freq_meter SHALL contain only clk-domain logic: FSM, window timer and sample registers.

Verification
REQ-037 clk 10 ns, ro_in 3.333 ns, win_cycles=100 -> valid after 111 cycles, count in 298..302, overflow=0.
REQ-038 CNT_W=8, ro_in 5 ns, win_cycles=200 -> count=255, overflow=1, valid=1.
REQ-039 win_cycles=0 -> count=0, valid at cycle 11, ro_activate high cycles 1..8 only.
REQ-040 start re-pulsed during GATE -> ignored: window length, count and latency are unchanged from a single start.
REQ-041 rst pulsed in cycle 50 of a 100-cycle GATE -> ro_activate=0 and busy=0 immediately; after release, a new start with win_cycles=10 yields a correct count and no stale overflow.
REQ-042 In DONE, a new start with ro_in stopped -> valid drops the next cycle, then returns with count=0.

Source files
------------

// File: rtl/ro_meter_pkg.sv
// Shared encodings and fixed phase lengths for the ring-oscillator frequency meter.
`timescale 1ns/1ps
package ro_meter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        GATE   = 3'd2,
        DRAIN  = 3'd3,
        SAMPLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int DRAIN_CYC      = 4;
    localparam int SAMPLE_CYC     = 2;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_WIN_W      = 16;
    localparam int DEF_SETTLE_CYC = 4;

endpackage

// File: rtl/ro_edge_counter.sv
// RO-clocked edge counter: gate synchronizer, saturating count, sticky overflow.
`timescale 1ns/1ps
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             ro_in,
    input  logic             clr,
    input  logic             gate,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [1:0] gate_sync;

    always_ff @(posedge ro_in or posedge clr) begin
        if (clr) begin
            gate_sync <= 2'b00;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            gate_sync <= {gate_sync[0], gate};
            if (gate_sync[1]) begin
                // Hold at full scale; the sticky flag records the lost edges.
                if (&count) overflow <= 1'b1;
                else        count    <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ro_freq_meter.sv
// Clock-domain control for the RO frequency meter: FSM, window timer, result sampling.
`timescale 1ns/1ps
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_W      = DEF_WIN_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_cycles,
    input  logic             ro_in,
    output logic             ro_activate,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int TMR_W = (WIN_W > 8) ? WIN_W : 8;

    state_t             state, next;
    logic [TMR_W-1:0]   tmr;
    logic [WIN_W-1:0]   win_q;
    logic [TMR_W-1:0]   win_ext;
    logic               last;
    logic               accept;
    logic               gate;
    logic               clr_q;
    logic [CNT_W-1:0]   ro_cnt, cnt_s1, cnt_s2;
    logic               ro_ovf, ovf_s1, ovf_s2;

    assign win_ext = TMR_W'(win_q);
    assign accept  = start && (state == IDLE || state == DONE);
    assign busy    = (state != IDLE) && (state != DONE);

    always_comb begin
        next = state;
        last = 1'b0;
        case (state)
            IDLE, DONE: if (start) next = SETTLE;
            SETTLE: begin
                last = (tmr == TMR_W'(SETTLE_CYC - 1));
                if (last) next = (win_q == '0) ? DRAIN : GATE;
            end
            GATE: begin
                last = (tmr == win_ext - TMR_W'(1));
                if (last) next = DRAIN;
            end
            DRAIN: begin
                last = (tmr == TMR_W'(DRAIN_CYC - 1));
                if (last) next = SAMPLE;
            end
            SAMPLE: begin
                last = (tmr == TMR_W'(SAMPLE_CYC - 1));
                if (last) next = DONE;
            end
            default: next = IDLE;
        endcase
    end

    // Gate, activate and valid are registered from the current state so they
    // leave the block glitch-free; all three lag the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= '0;
            win_q       <= '0;
            gate        <= 1'b0;
            ro_activate <= 1'b0;
            valid       <= 1'b0;
            clr_q       <= 1'b1;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= next;
            tmr         <= (next != state || !busy) ? '0 : tmr + 1'b1;
            gate        <= (state == GATE);
            ro_activate <= (state == SETTLE) || (state == GATE) || (state == DRAIN);
            valid       <= (state == DONE) && !accept;
            clr_q       <= accept || (state == IDLE);
            if (accept) begin
                win_q    <= win_cycles;
                count    <= '0;
                overflow <= 1'b0;
            end else if (state == SAMPLE && last) begin
                count    <= cnt_s2;
                overflow <= ovf_s2;
            end
        end
    end

    // The RO count is static by SAMPLE, so a plain two-flop bus capture is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_s1 <= '0;
            cnt_s2 <= '0;
            ovf_s1 <= 1'b0;
            ovf_s2 <= 1'b0;
        end else begin
            cnt_s1 <= ro_cnt;
            cnt_s2 <= cnt_s1;
            ovf_s1 <= ro_ovf;
            ovf_s2 <= ovf_s1;
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .ro_in    (ro_in),
        .clr      (rst | clr_q),
        .gate     (gate),
        .count    (ro_cnt),
        .overflow (ro_ovf)
    );

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: default instance plus an 8-bit-count instance.
`timescale 1ns/1ps
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start8;
    logic [15:0] win_cycles, win8;
    logic        ro_in, ro8;
    logic        ro_activate, busy, valid, overflow;
    logic [15:0] count;
    logic        act8, busy8, valid8, ovf8;
    logic [7:0]  count8;
    logic        ro_run = 1'b1;
    logic        ro_run8 = 1'b1;
    real         half_a = 1.6665;
    real         half_b = 2.5;
    int          n_pass = 0;
    int          n_tot  = 0;

    always #5 clk = ~clk;

    // Ring oscillator models: they only run while the DUT requests activation.
    always begin
        ro_in = 1'b0;
        wait (ro_activate && ro_run);
        while (ro_activate && ro_run) #(half_a) ro_in = ~ro_in;
    end

    always begin
        ro8 = 1'b0;
        wait (act8 && ro_run8);
        while (act8 && ro_run8) #(half_b) ro8 = ~ro8;
    end

    ro_freq_meter dut (
        .clk(clk), .rst(rst), .start(start), .win_cycles(win_cycles), .ro_in(ro_in),
        .ro_activate(ro_activate), .busy(busy), .valid(valid), .count(count), .overflow(overflow)
    );

    ro_freq_meter #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .win_cycles(win8), .ro_in(ro8),
        .ro_activate(act8), .busy(busy8), .valid(valid8), .count(count8), .overflow(ovf8)
    );

    task automatic pulse_start(input logic [15:0] w);
        @(negedge clk);
        win_cycles = w;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start8 = 1'b0; win_cycles = '0; win8 = '0;
        #12;
        n_tot++;
        if ({ro_activate, busy, valid, overflow, count} !== 20'h0) begin
            $display("FAIL reset_state: act=%b busy=%b valid=%b ovf=%b count=%0d, want all 0",
                     ro_activate, busy, valid, overflow, count);
        end else n_pass++;
        n_tot++;
        if ({act8, busy8, valid8, ovf8, count8} !== 12'h0) begin
            $display("FAIL reset_state8: act=%b busy=%b valid=%b ovf=%b count=%0d, want all 0",
                     act8, busy8, valid8, ovf8, count8);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nominal;
        int lat;
        pulse_start(16'd100);
        wait_valid(lat);
        n_tot++;
        if (lat !== 111) $display("FAIL nominal_latency: got %0d, want 111", lat);
        else n_pass++;
        n_tot++;
        if (count < 16'd298 || count > 16'd302) $display("FAIL nominal_count: got %0d, want 298..302", count);
        else n_pass++;
        n_tot++;
        if (overflow !== 1'b0 || busy !== 1'b0) $display("FAIL nominal_flags: ovf=%b busy=%b, want 0 0", overflow, busy);
        else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_tot++;
        if (valid !== 1'b1 || count < 16'd298 || count > 16'd302 || ro_activate !== 1'b0)
            $display("FAIL nominal_hold: valid=%b count=%0d act=%b, want 1 298..302 0", valid, count, ro_activate);
        else n_pass++;
    endtask

    task automatic test_restart_ignored;
        int lat;
        pulse_start(16'd100);
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (n == 50) begin
                start = 1'b1;
                win_cycles = 16'd7;
            end else start = 1'b0;
            if (valid) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        n_tot++;
        if (lat !== 111) $display("FAIL restart_latency: got %0d, want 111", lat);
        else n_pass++;
        n_tot++;
        if (count < 16'd298 || count > 16'd302) $display("FAIL restart_count: got %0d, want 298..302", count);
        else n_pass++;
    endtask

    task automatic test_win_zero;
        logic [15:0] act_seen;
        int lat;
        act_seen = '0;
        lat = -1;
        pulse_start(16'd0);
        act_seen[0] = ro_activate;
        for (int n = 1; n < 16; n++) begin
            @(posedge clk);
            #1;
            act_seen[n] = ro_activate;
            if (valid && lat < 0) lat = n;
        end
        n_tot++;
        if (lat !== 11) $display("FAIL zero_latency: got %0d, want 11", lat);
        else n_pass++;
        n_tot++;
        if (act_seen !== 16'h01FE) $display("FAIL zero_activate: got %h, want 01fe", act_seen);
        else n_pass++;
        n_tot++;
        if (count !== 16'd0 || overflow !== 1'b0) $display("FAIL zero_count: got %0d ovf=%b, want 0 0", count, overflow);
        else n_pass++;
    endtask

    task automatic test_done_restart_stopped;
        int lat;
        ro_run = 1'b0;
        pulse_start(16'd20);
        n_tot++;
        if (valid !== 1'b0 || count !== 16'd0 || busy !== 1'b1)
            $display("FAIL done_restart_clear: valid=%b count=%0d busy=%b, want 0 0 1", valid, count, busy);
        else n_pass++;
        wait_valid(lat);
        n_tot++;
        if (lat !== 31 || count !== 16'd0 || overflow !== 1'b0)
            $display("FAIL done_restart_result: lat=%0d count=%0d ovf=%b, want 31 0 0", lat, count, overflow);
        else n_pass++;
        ro_run = 1'b1;
    endtask

    task automatic test_abort;
        int lat;
        pulse_start(16'd100);
        repeat (54) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tot++;
        if (ro_activate !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || count !== 16'd0)
            $display("FAIL abort_reset: act=%b busy=%b valid=%b count=%0d, want 0 0 0 0",
                     ro_activate, busy, valid, count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        win_cycles = 16'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_tot++;
        if (busy !== 1'b1) $display("FAIL abort_first_edge_start: busy=%b, want 1", busy);
        else n_pass++;
        wait_valid(lat);
        n_tot++;
        if (lat !== 21) $display("FAIL abort_latency: got %0d, want 21", lat);
        else n_pass++;
        n_tot++;
        if (count < 16'd28 || count > 16'd32 || overflow !== 1'b0)
            $display("FAIL abort_count: got %0d ovf=%b, want 28..32 0", count, overflow);
        else n_pass++;
    endtask

    task automatic test_overflow;
        int lat;
        lat = -1;
        @(negedge clk);
        win8 = 16'd200;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (valid8) begin
                lat = n;
                break;
            end
        end
        n_tot++;
        if (lat !== 211) $display("FAIL ovf_latency: got %0d, want 211", lat);
        else n_pass++;
        n_tot++;
        if (count8 !== 8'd255 || ovf8 !== 1'b1 || valid8 !== 1'b1)
            $display("FAIL ovf_result: count=%0d ovf=%b valid=%b, want 255 1 1", count8, ovf8, valid8);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_restart_ignored();
        test_win_zero();
        test_done_restart_stopped();
        test_abort();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
